// File: rtl/stream_scheduler.sv
// stream_scheduler: cuts the quantized sample stream into fixed-length packets
// for the streamer's ping-pong buffers. A whole packet is dropped when the next
// bank is still busy at its first word. A free-running timer, or a software
// request, raises status_ready for a fixed number of cycles. The streamer
// starts a status packet on the falling edge of status_ready.
module stream_scheduler #(
    parameter int PKT_WORDS     = 512,
    parameter int STATUS_PERIOD = 1000000,
    parameter int STATUS_HIGH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_req,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    input  logic        buf_free,
    input  logic        status_req,
    output logic [15:0] out_data,
    output logic        out_en,
    output logic        out_packet_end,
    output logic        status_ready,
    output logic        active,
    output logic [31:0] sent_count,
    output logic [31:0] drop_count
);

    localparam int WCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_WORDS - 1);

    localparam int TMR_W = $clog2(STATUS_PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STATUS_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'(STATUS_PERIOD - 2);

    localparam int HI_W = (STATUS_HIGH > 1) ? $clog2(STATUS_HIGH + 1) : 1;
    localparam logic [HI_W-1:0] HI_LOAD = HI_W'(STATUS_HIGH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [WCNT_W-1:0] wcnt;
    logic              keep;

    logic              accept;
    logic              pkt_start;
    logic              pkt_last;
    logic              forward;

    logic [TMR_W-1:0]  timer;
    logic [HI_W-1:0]   hi_cnt;
    logic              status_trigger;

    // Buffer-free is only consulted on the first word, so a packet is never split.
    assign accept    = (state == RUN) && sample_valid;
    assign pkt_start = accept && (wcnt == '0);
    assign pkt_last  = accept && (wcnt == LAST_WORD);
    assign forward   = accept && (pkt_start ? buf_free : keep);

    // The pulse is launched one cycle early so that status_ready is already
    // high in the cycle where the timer sits on its last count.
    assign status_trigger = status_req || (timer == TMR_PRE);

    // Next-state logic: leave RUN only at a packet boundary.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (enable_req) state_d = RUN;
            RUN:  if (pkt_last && !enable_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Packet datapath: word counter, keep flag, registered output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt           <= '0;
            keep           <= 1'b0;
            out_data       <= '0;
            out_en         <= 1'b0;
            out_packet_end <= 1'b0;
            active         <= 1'b0;
        end else begin
            if (accept) begin
                wcnt <= pkt_last ? '0 : wcnt + WCNT_W'(1);
            end
            if (pkt_start) begin
                keep <= buf_free;
            end
            out_data       <= forward ? sample_data : '0;
            out_en         <= forward;
            out_packet_end <= forward && pkt_last;
            active         <= (state_d == RUN);
        end
    end

    // Saturating packet counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_count <= '0;
            drop_count <= '0;
        end else begin
            if (forward && pkt_last && (sent_count != '1)) begin
                sent_count <= sent_count + 32'd1;
            end
            if (pkt_start && !buf_free && (drop_count != '1)) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    // Status timer and fixed-width status_ready pulse; triggers while high are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            hi_cnt       <= '0;
            status_ready <= 1'b0;
        end else begin
            if (status_req || (timer == TMR_LAST)) timer <= '0;
            else                                   timer <= timer + TMR_W'(1);

            if (status_ready) begin
                if (hi_cnt == '0) status_ready <= 1'b0;
                else              hi_cnt       <= hi_cnt - HI_W'(1);
            end else if (status_trigger) begin
                status_ready <= 1'b1;
                hi_cnt       <= HI_LOAD;
            end
        end
    end

endmodule
